// File: rtl/hamming_frame_encoder_pkg.sv
// Shared constants for the Hamming frame encoder: parity masks over nibble bits,
// codeword width helper and transmit FSM state encodings.
package hamming_frame_pkg;

    // Bit i of each mask selects data bit d_i into the corresponding parity bit.
    localparam logic [3:0] P0_MASK = 4'b1011;
    localparam logic [3:0] P1_MASK = 4'b1101;
    localparam logic [3:0] P2_MASK = 4'b1110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    function automatic int cw_width(input int ext);
        return 7 + ext;
    endfunction

endpackage

// File: rtl/hamming_frame_encoder_if.sv
// Serial input and serial frame output handshakes of the Hamming frame encoder.
interface hamming_frame_encoder_if;
    logic        in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic [15:0] frame_cnt;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sof, frame_cnt
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sof, frame_cnt
    );
endinterface

// File: rtl/hamming_frame_encoder_hamming74_enc.sv
// Combinational Hamming(7,4) nibble encoder, optionally extended with an
// overall parity LSB to give an (8,4) SECDED codeword.
module hamming74_enc
    import hamming_frame_pkg::*;
#(
    parameter int EXT_PARITY = 0,
    localparam int CW_W = cw_width(EXT_PARITY)
) (
    input  logic [3:0]      nibble_i,
    output logic [CW_W-1:0] cw_o
);
    logic       p0;
    logic       p1;
    logic       p2;
    logic [6:0] cw7;

    assign p0  = ^(nibble_i & P0_MASK);
    assign p1  = ^(nibble_i & P1_MASK);
    assign p2  = ^(nibble_i & P2_MASK);
    assign cw7 = {nibble_i[3], nibble_i[2], nibble_i[1], p2, nibble_i[0], p1, p0};

    generate
        if (EXT_PARITY != 0) begin : g_ext
            assign cw_o = {cw7, ^cw7};
        end else begin : g_plain
            assign cw_o = cw7;
        end
    endgenerate

endmodule

// File: rtl/hamming_frame_encoder.sv
// Serial Hamming frame encoder: assembles a word from a bit stream, encodes it
// nibble by nibble and shifts out {sync, codewords} MSB first under backpressure.
module hamming_frame_encoder
    import hamming_frame_pkg::*;
#(
    parameter int                N_NIBBLES  = 8,
    parameter int                SYNC_W     = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_W'(8'h7E),
    parameter int                EXT_PARITY = 0
) (
    input logic                    clk_in,
    input logic                    rst,
    hamming_frame_encoder_if.slave bus
);
    localparam int DATA_W  = 4 * N_NIBBLES;
    localparam int CW_W    = cw_width(EXT_PARITY);
    localparam int FRAME_W = SYNC_W + N_NIBBLES * CW_W;
    localparam int ASM_W   = $clog2(DATA_W);
    localparam int IDX_W   = $clog2(FRAME_W);

    logic [DATA_W-1:0]         asm_word_q, asm_word_d;
    logic [ASM_W-1:0]          asm_cnt_q, asm_cnt_d;
    logic                      asm_full_q, asm_full_d;
    logic [FRAME_W-1:0]        tx_frame_q, tx_frame_d;
    logic [IDX_W-1:0]          tx_idx_q, tx_idx_d;
    logic [0:0]                state_q, state_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic [N_NIBBLES*CW_W-1:0] cw_all;
    logic                      in_xfer;
    logic                      out_xfer;
    logic                      last_bit;
    logic                      load;

    generate
        for (genvar gi = 0; gi < N_NIBBLES; gi++) begin : g_enc
            hamming74_enc #(.EXT_PARITY(EXT_PARITY)) u_enc (
                .nibble_i (asm_word_q[4*gi +: 4]),
                .cw_o     (cw_all[CW_W*gi +: CW_W])
            );
        end
    endgenerate

    assign in_xfer  = bus.in_valid && !asm_full_q;
    assign out_xfer = (state_q == ST_SEND) && bus.out_ready;
    assign last_bit = out_xfer && (tx_idx_q == IDX_W'(FRAME_W - 1));
    // A full word is loaded from IDLE, or on the final bit so frames run back to back.
    assign load     = asm_full_q && ((state_q == ST_IDLE) || last_bit);

    always_comb begin
        asm_word_d  = asm_word_q;
        asm_cnt_d   = asm_cnt_q;
        asm_full_d  = asm_full_q;
        tx_frame_d  = tx_frame_q;
        tx_idx_d    = tx_idx_q;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;

        if (in_xfer) begin
            asm_word_d = {asm_word_q[DATA_W-2:0], bus.in_data};
            if (asm_cnt_q == ASM_W'(DATA_W - 1)) begin
                asm_cnt_d  = '0;
                asm_full_d = 1'b1;
            end else begin
                asm_cnt_d = asm_cnt_q + ASM_W'(1);
            end
        end

        if (load) begin
            asm_full_d  = 1'b0;
            tx_frame_d  = {SYNC_WORD, cw_all};
            tx_idx_d    = '0;
            state_d     = ST_SEND;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (out_xfer) begin
            // Zero fill leaves the register clear once a frame has fully drained.
            tx_frame_d = {tx_frame_q[FRAME_W-2:0], 1'b0};
            if (last_bit) begin
                tx_idx_d = '0;
                state_d  = ST_IDLE;
            end else begin
                tx_idx_d = tx_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            asm_word_q  <= '0;
            asm_cnt_q   <= '0;
            asm_full_q  <= 1'b0;
            tx_frame_q  <= '0;
            tx_idx_q    <= '0;
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else begin
            asm_word_q  <= asm_word_d;
            asm_cnt_q   <= asm_cnt_d;
            asm_full_q  <= asm_full_d;
            tx_frame_q  <= tx_frame_d;
            tx_idx_q    <= tx_idx_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.in_ready  = !asm_full_q;
    assign bus.out_valid = (state_q == ST_SEND);
    assign bus.out_data  = tx_frame_q[FRAME_W-1];
    assign bus.out_sof   = (state_q == ST_SEND) && (tx_idx_q == '0);
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Directed bench for hamming_frame_encoder: default 32-bit/7-bit-codeword instance
// plus a 2-nibble extended-parity instance, checked with hand-computed frames.
module tb_hamming_frame_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hamming_frame_encoder_if a_if();
    hamming_frame_encoder_if b_if();

    hamming_frame_encoder u_a (
        .clk_in (clk),
        .rst    (rst),
        .bus    (a_if.slave)
    );

    hamming_frame_encoder #(
        .N_NIBBLES  (2),
        .SYNC_W     (8),
        .SYNC_WORD  (8'h7E),
        .EXT_PARITY (1)
    ) u_b (
        .clk_in (clk),
        .rst    (rst),
        .bus    (b_if.slave)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [255:0] got;
    int           sof_bad;
    int           stall_bad;
    int           gaps;
    int           throttle;
    int           nbits_got;
    int           feed_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input int k, input int nf, input int fw);
        logic [255:0] t;
        t = got >> ((nf - 1 - k) * fw);
        return (fw == 64) ? t[63:0] : (t[63:0] & ((64'd1 << fw) - 64'd1));
    endfunction

    // Feeds cnt bits of w (MSB of the dw-bit word first), honouring in_ready.
    task automatic feed_bits(input bit sel, input logic [31:0] w, input int dw, input int cnt);
        logic ir;
        int   k;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (sel) begin b_if.in_valid = 1'b1; b_if.in_data = w[dw-1-i]; end
            else     begin a_if.in_valid = 1'b1; a_if.in_data = w[dw-1-i]; end
            k  = 0;
            ir = sel ? b_if.in_ready : a_if.in_ready;
            while (!ir && k < 300) begin
                @(negedge clk);
                k++;
                ir = sel ? b_if.in_ready : a_if.in_ready;
            end
            if (k >= 300) feed_to++;
        end
    endtask

    // Streams nw words in while collecting nbits output bits into got.
    task automatic run(input bit sel, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input int nw, input int dw, input int fw,
                       input int nbits, input bit stall, input bit gapchk);
        logic        ov, od, os, ir, rdy, pd, ps, prev_stall;
        logic [31:0] w;
        int          bp, cyc;
        got = '0; sof_bad = 0; stall_bad = 0; gaps = 0; throttle = 0;
        bp = 0; cyc = 0; nbits_got = 0; prev_stall = 1'b0; pd = 1'b0; ps = 1'b0;
        while (nbits_got < nbits && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            ov = sel ? b_if.out_valid : a_if.out_valid;
            od = sel ? b_if.out_data  : a_if.out_data;
            os = sel ? b_if.out_sof   : a_if.out_sof;
            ir = sel ? b_if.in_ready  : a_if.in_ready;
            if (prev_stall && (!ov || od !== pd || os !== ps)) stall_bad++;
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sel) b_if.out_ready = rdy; else a_if.out_ready = rdy;
            if (bp < nw * dw) begin
                w = (bp / dw == 0) ? w0 : ((bp / dw == 1) ? w1 : w2);
                if (sel) begin b_if.in_valid = 1'b1; b_if.in_data = w[dw-1-(bp%dw)]; end
                else     begin a_if.in_valid = 1'b1; a_if.in_data = w[dw-1-(bp%dw)]; end
                if (!ir) throttle++;
                else     bp++;
            end else begin
                if (sel) b_if.in_valid = 1'b0; else a_if.in_valid = 1'b0;
            end
            if (ov && rdy) begin
                got = {got[254:0], od};
                if (os !== ((nbits_got % fw) == 0)) sof_bad++;
                nbits_got++;
            end else if (!ov && gapchk && nbits_got > 0) begin
                gaps++;
            end
            prev_stall = ov && !rdy;
            pd = od;
            ps = os;
        end
        @(negedge clk);
        if (sel) begin b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; end
        else     begin a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        feed_to = 0;
        a_if.in_data = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_data = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_in_ready",  64'(a_if.in_ready),  64'd1);
        check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst_out_data",  64'(a_if.out_data),  64'd0);
        check("rst_out_sof",   64'(a_if.out_sof),   64'd0);
        check("rst_frame_cnt", 64'(a_if.frame_cnt), 64'd0);
        check("rst_b_valid",   64'(b_if.out_valid), 64'd0);

        // Extended parity, 2 nibbles, two back-to-back frames: 0x81 then 0x18.
        run(1'b1, 32'h81, 32'h18, 32'h0, 2, 8, 24, 48, 1'b0, 1'b1);
        check("ext_bits",      64'(nbits_got), 64'd48);
        check("ext_frame_81",  frame_of(0, 2, 24), 64'h7E960F);
        check("ext_frame_18",  frame_of(1, 2, 24), 64'h7E0F96);
        check("ext_sof",       64'(sof_bad), 64'd0);
        check("ext_gaps",      64'(gaps), 64'd0);
        check("ext_frame_cnt", 64'(b_if.frame_cnt), 64'd2);

        // All-zero word: sync then 56 zeros.
        run(1'b0, 32'h0, 32'h0, 32'h0, 1, 32, 64, 64, 1'b0, 1'b0);
        check("zero_bits",      64'(nbits_got), 64'd64);
        check("zero_frame",     frame_of(0, 1, 64), 64'h7E00_0000_0000_0000);
        check("zero_sof",       64'(sof_bad), 64'd0);
        check("zero_frame_cnt", 64'(a_if.frame_cnt), 64'd1);
        check("zero_idle",      64'(a_if.out_valid), 64'd0);

        // Load timing with the output stalled: word 0x000000F1.
        feed_bits(1'b0, 32'h0000_00F1, 32, 32);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        check("full_in_ready",   64'(a_if.in_ready),  64'd0);
        check("full_out_valid",  64'(a_if.out_valid), 64'd0);
        @(negedge clk);
        check("load_out_valid",  64'(a_if.out_valid), 64'd1);
        check("load_out_sof",    64'(a_if.out_sof),   64'd1);
        check("load_out_data",   64'(a_if.out_data),  64'd0);
        check("load_in_ready",   64'(a_if.in_ready),  64'd1);
        check("load_frame_cnt",  64'(a_if.frame_cnt), 64'd2);
        run(1'b0, 32'h0, 32'h0, 32'h0, 0, 32, 64, 64, 1'b0, 1'b0);
        check("f1_frame", frame_of(0, 1, 64), 64'h7E00_0000_0000_3F87);
        check("f1_sof",   64'(sof_bad), 64'd0);

        // Random backpressure on word 0x80000008.
        run(1'b0, 32'h8000_0008, 32'h0, 32'h0, 1, 32, 64, 64, 1'b1, 1'b0);
        check("bp_bits",      64'(nbits_got), 64'd64);
        check("bp_frame",     frame_of(0, 1, 64), 64'h7E96_0000_0000_004B);
        check("bp_stable",    64'(stall_bad), 64'd0);
        check("bp_sof",       64'(sof_bad), 64'd0);
        check("bp_frame_cnt", 64'(a_if.frame_cnt), 64'd3);

        // Continuous input, three words, frames must run back to back.
        do_reset();
        run(1'b0, 32'h0000_00F1, 32'h8000_0008, 32'hFFFF_FFFF, 3, 32, 64, 192, 1'b0, 1'b1);
        check("b2b_bits",      64'(nbits_got), 64'd192);
        check("b2b_frame0",    frame_of(0, 3, 64), 64'h7E00_0000_0000_3F87);
        check("b2b_frame1",    frame_of(1, 3, 64), 64'h7E96_0000_0000_004B);
        check("b2b_frame2",    frame_of(2, 3, 64), 64'h7EFF_FFFF_FFFF_FFFF);
        check("b2b_gaps",      64'(gaps), 64'd0);
        check("b2b_sof",       64'(sof_bad), 64'd0);
        check("b2b_throttle",  (throttle > 0) ? 64'd1 : 64'd0, 64'd1);
        check("b2b_frame_cnt", 64'(a_if.frame_cnt), 64'd3);

        // Asynchronous reset in the middle of a frame and a partial word.
        feed_bits(1'b0, 32'hFFFF_FFFF, 32, 32);
        feed_bits(1'b0, 32'h1234_5678, 32, 10);
        @(negedge clk);
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check("mid_rst_out_data",  64'(a_if.out_data),  64'd0);
        check("mid_rst_out_sof",   64'(a_if.out_sof),   64'd0);
        check("mid_rst_in_ready",  64'(a_if.in_ready),  64'd1);
        check("mid_rst_frame_cnt", 64'(a_if.frame_cnt), 64'd0);
        @(negedge clk);
        a_if.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 32'h0000_00F1, 32'h0, 32'h0, 1, 32, 64, 64, 1'b0, 1'b0);
        check("post_rst_bits",      64'(nbits_got), 64'd64);
        check("post_rst_frame",     frame_of(0, 1, 64), 64'h7E00_0000_0000_3F87);
        check("post_rst_sof",       64'(sof_bad), 64'd0);
        check("post_rst_frame_cnt", 64'(a_if.frame_cnt), 64'd1);
        check("feed_timeouts",      64'(feed_to), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
